// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_writeback_arbiter_pkg;

    localparam int RF_NUM_REGS   = 16;
    localparam int RF_SEL_WIDTH  = $clog2(RF_NUM_REGS);
    localparam int RF_DATA_WIDTH = 32;
    localparam int NUM_WB_SRCS   = 3;

    // Result producers, in arbitration index order.
    typedef enum logic [1:0] {
        SRC_ALU    = 2'd0,
        SRC_MEM    = 2'd1,
        SRC_MULDIV = 2'd2
    } SrcId;

    // One producer's writeback request.
    typedef struct packed {
        logic                     valid;
        logic [RF_SEL_WIDTH-1:0]  sel;
        logic [RF_DATA_WIDTH-1:0] data;
    } PortIn_WbSrc;

    // Round-robin successor of a source index (wraps 2 -> 0).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_rr.sv
// Combinational round-robin arbiter over the three writeback producers.
module writeback_rr_arbiter
    import regfile_writeback_arbiter_pkg::*;
(
    input  logic [NUM_WB_SRCS-1:0] req,
    input  logic [1:0]             rr_ptr,
    output logic [NUM_WB_SRCS-1:0] grant,
    output logic [1:0]             grant_idx
);

    logic       found;
    logic [1:0] base;
    logic [1:0] cand;
    logic [2:0] sum;

    // Walk the requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        // rr_ptr never holds 3; map it to 0 so the search stays well defined.
        base      = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
        for (int k = 0; k < NUM_WB_SRCS; k++) begin
            sum  = {1'b0, base} + 3'(k);
            cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write port arbiter with per-register busy scoreboard.
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int SEL_WIDTH  = RF_SEL_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  issue_valid,
    input  logic [SEL_WIDTH-1:0]                  issue_sel,
    output logic                                  issue_ready,
    input  logic [SEL_WIDTH-1:0]                  chk_sel_ra,
    input  logic [SEL_WIDTH-1:0]                  chk_sel_rb,
    input  logic [SEL_WIDTH-1:0]                  chk_sel_rc,
    output logic                                  busy_ra,
    output logic                                  busy_rb,
    output logic                                  busy_rc,
    input  logic [NUM_WB_SRCS-1:0]                src_valid,
    input  logic [NUM_WB_SRCS-1:0][SEL_WIDTH-1:0] src_sel,
    input  logic [NUM_WB_SRCS-1:0][DATA_WIDTH-1:0] src_data,
    output logic [NUM_WB_SRCS-1:0]                src_ready,
    output logic                                  rf_write_en,
    output logic [SEL_WIDTH-1:0]                  rf_write_sel,
    output logic [DATA_WIDTH-1:0]                 rf_write_data
);

    logic [NUM_REGS-1:0]    busy_q, busy_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic                   rf_we_q, rf_we_d;
    logic [SEL_WIDTH-1:0]   rf_sel_q, rf_sel_d;
    logic [DATA_WIDTH-1:0]  rf_data_q, rf_data_d;

    logic [NUM_WB_SRCS-1:0] grant;
    logic [1:0]             grant_idx;
    logic                   any_grant;
    logic [SEL_WIDTH-1:0]   win_sel;
    logic [DATA_WIDTH-1:0]  win_data;
    logic                   issue_take;

    writeback_rr_arbiter u_arb (
        .req       (src_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign any_grant = |grant;
    assign win_sel   = src_sel[grant_idx];
    assign win_data  = src_data[grant_idx];
    assign src_ready = grant;

    // Hazard lookups and issue acceptance read the registered scoreboard only,
    // so a register being cleared this cycle still reads busy (conservative).
    assign busy_ra     = busy_q[chk_sel_ra];
    assign busy_rb     = busy_q[chk_sel_rb];
    assign busy_rc     = busy_q[chk_sel_rc];
    assign issue_ready = (issue_sel == '0) || !busy_q[issue_sel];
    assign issue_take  = issue_valid && issue_ready && (issue_sel != '0) && !flush;

    assign rf_write_en   = rf_we_q;
    assign rf_write_sel  = rf_sel_q;
    assign rf_write_data = rf_data_q;

    // Next-state: writeback clear, then issue set, flush overrides both; r0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (any_grant) begin
            busy_d[win_sel] = 1'b0;
        end
        if (issue_take) begin
            busy_d[issue_sel] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;

        rr_ptr_d  = any_grant ? rr_next(grant_idx) : rr_ptr_q;
        rf_we_d   = any_grant && (win_sel != '0);
        rf_sel_d  = any_grant ? win_sel  : rf_sel_q;
        rf_data_d = any_grant ? win_data : rf_data_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            rr_ptr_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_sel_q  <= '0;
            rf_data_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rr_ptr_q  <= rr_ptr_d;
            rf_we_q   <= rf_we_d;
            rf_sel_q  <= rf_sel_d;
            rf_data_q <= rf_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed, table-driven bench for the writeback arbiter.
module tb_regfile_writeback_arbiter;
    import regfile_writeback_arbiter_pkg::*;

    logic                            clk;
    logic                            rst_n;
    logic                            flush;
    logic                            issue_valid;
    logic [3:0]                      issue_sel;
    logic                            issue_ready;
    logic [3:0]                      chk_sel_ra, chk_sel_rb, chk_sel_rc;
    logic                            busy_ra, busy_rb, busy_rc;
    logic [2:0]                      src_valid;
    logic [2:0][3:0]                 src_sel;
    logic [2:0][31:0]                src_data;
    logic [2:0]                      src_ready;
    logic                            rf_write_en;
    logic [3:0]                      rf_write_sel;
    logic [31:0]                     rf_write_data;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_writeback_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_sel     (issue_sel),
        .issue_ready   (issue_ready),
        .chk_sel_ra    (chk_sel_ra),
        .chk_sel_rb    (chk_sel_rb),
        .chk_sel_rc    (chk_sel_rc),
        .busy_ra       (busy_ra),
        .busy_rb       (busy_rb),
        .busy_rc       (busy_rc),
        .src_valid     (src_valid),
        .src_sel       (src_sel),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .rf_write_en   (rf_write_en),
        .rf_write_sel  (rf_write_sel),
        .rf_write_data (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1);
    end

    typedef struct {
        logic        fl;
        logic        iv;
        logic [3:0]  is;
        logic [3:0]  ra, rb, rc;
        logic [2:0]  sv;
        logic [3:0]  s0, s1, s2;
        logic [31:0] d0, d1, d2;
        logic        e_ir;
        logic [2:0]  e_busy;   // {rc, rb, ra}
        logic [2:0]  e_rdy;
        logic        e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic fl, input logic iv, input logic [3:0] is,
                        input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                        input logic [2:0] sv,
                        input logic [3:0] s0, input logic [31:0] d0,
                        input logic [3:0] s1, input logic [31:0] d1,
                        input logic [3:0] s2, input logic [31:0] d2,
                        input logic e_ir, input logic [2:0] e_busy, input logic [2:0] e_rdy,
                        input logic e_we, input logic [3:0] e_sel, input logic [31:0] e_data);
        vec_t v;
        v.fl = fl; v.iv = iv; v.is = is; v.ra = ra; v.rb = rb; v.rc = rc; v.sv = sv;
        v.s0 = s0; v.d0 = d0; v.s1 = s1; v.d1 = d1; v.s2 = s2; v.d2 = d2;
        v.e_ir = e_ir; v.e_busy = e_busy; v.e_rdy = e_rdy;
        v.e_we = e_we; v.e_sel = e_sel; v.e_data = e_data;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        flush       = v.fl;
        issue_valid = v.iv;
        issue_sel   = v.is;
        chk_sel_ra  = v.ra;
        chk_sel_rb  = v.rb;
        chk_sel_rc  = v.rc;
        src_valid   = v.sv;
        src_sel[0]  = v.s0; src_data[0] = v.d0;
        src_sel[1]  = v.s1; src_data[1] = v.d1;
        src_sel[2]  = v.s2; src_data[2] = v.d2;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_sel = 4'd4;
        chk_sel_ra = 4'd1; chk_sel_rb = 4'd2; chk_sel_rc = 4'd3;
        src_valid = '0; src_sel = '0; src_data = '0;

        //   fl iv is  ra rb rc  sv      s0 d0            s1 d1          s2 d2             ir busy    rdy     we sel data
        addv(0, 1, 5,  5, 0, 0, 3'b000, 0, 0,            0, 0,           0, 0,             1, 3'b000, 3'b000, 0, 0,  32'h0);
        addv(0, 0, 0,  5, 0, 0, 3'b001, 5, 32'hDEADBEEF, 0, 0,           0, 0,             1, 3'b001, 3'b001, 1, 5,  32'hDEADBEEF);
        addv(0, 0, 0,  5, 0, 0, 3'b000, 0, 0,            0, 0,           0, 0,             1, 3'b000, 3'b000, 0, 5,  32'hDEADBEEF);
        addv(0, 0, 0,  1, 0, 0, 3'b100, 0, 0,            0, 0,           1, 32'h11,        1, 3'b000, 3'b100, 1, 1,  32'h11);
        addv(0, 0, 0,  2, 3, 4, 3'b111, 2, 32'hA0,       3, 32'hB0,      4, 32'hC0,        1, 3'b000, 3'b001, 1, 2,  32'hA0);
        addv(0, 0, 0,  2, 3, 4, 3'b111, 2, 32'hA0,       3, 32'hB0,      4, 32'hC0,        1, 3'b000, 3'b010, 1, 3,  32'hB0);
        addv(0, 0, 0,  2, 3, 4, 3'b111, 2, 32'hA0,       3, 32'hB0,      4, 32'hC0,        1, 3'b000, 3'b100, 1, 4,  32'hC0);
        addv(0, 1, 7,  7, 0, 0, 3'b000, 0, 0,            0, 0,           0, 0,             1, 3'b000, 3'b000, 0, 4,  32'hC0);
        addv(0, 1, 7,  7, 0, 0, 3'b010, 0, 0,            7, 32'h77,      0, 0,             0, 3'b001, 3'b010, 1, 7,  32'h77);
        addv(0, 1, 7,  7, 0, 0, 3'b000, 0, 0,            0, 0,           0, 0,             1, 3'b000, 3'b000, 0, 7,  32'h77);
        addv(0, 0, 7,  7, 0, 0, 3'b000, 0, 0,            0, 0,           0, 0,             0, 3'b001, 3'b000, 0, 7,  32'h77);
        addv(0, 1, 0,  7, 0, 0, 3'b100, 0, 0,            0, 0,           0, 32'h12345678,  1, 3'b001, 3'b100, 0, 0,  32'h12345678);
        addv(0, 1, 2,  7, 0, 0, 3'b000, 0, 0,            0, 0,           0, 0,             1, 3'b001, 3'b000, 0, 0,  32'h12345678);
        addv(0, 1, 9,  2, 0, 0, 3'b000, 0, 0,            0, 0,           0, 0,             1, 3'b001, 3'b000, 0, 0,  32'h12345678);
        addv(1, 1, 3,  2, 9, 7, 3'b010, 0, 0,            6, 32'h66,      0, 0,             1, 3'b111, 3'b010, 1, 6,  32'h66);
        addv(0, 0, 0,  2, 9, 3, 3'b001, 9, 32'h99,       0, 0,           0, 0,             1, 3'b000, 3'b001, 1, 9,  32'h99);
        addv(0, 0, 0,  7, 9, 3, 3'b000, 0, 0,            0, 0,           0, 0,             1, 3'b000, 3'b000, 0, 9,  32'h99);
        addv(0, 0, 0,  0, 0, 0, 3'b110, 0, 0,            10, 32'hAA,     11, 32'hBB,       1, 3'b000, 3'b010, 1, 10, 32'hAA);
        addv(0, 0, 0,  0, 0, 0, 3'b110, 0, 0,            10, 32'hAA,     11, 32'hBB,       1, 3'b000, 3'b100, 1, 11, 32'hBB);

        // Reset state, held across clock edges.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_we",    0, 32'(rf_write_en),   32'h0);
        chk("rst_sel",   0, 32'(rf_write_sel),  32'h0);
        chk("rst_data",  0, rf_write_data,      32'h0);
        chk("rst_ir",    0, 32'(issue_ready),   32'h1);
        chk("rst_busy",  0, 32'({busy_rc, busy_rb, busy_ra}), 32'h0);
        chk("rst_rdy",   0, 32'(src_ready),     32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            @(negedge clk);
            chk("issue_ready", i, 32'(issue_ready), 32'(v.e_ir));
            chk("busy",        i, 32'({busy_rc, busy_rb, busy_ra}), 32'(v.e_busy));
            chk("src_ready",   i, 32'(src_ready), 32'(v.e_rdy));
            @(posedge clk); #1;
            chk("rf_we",   i, 32'(rf_write_en),  32'(v.e_we));
            chk("rf_sel",  i, 32'(rf_write_sel), 32'(v.e_sel));
            chk("rf_data", i, rf_write_data,     v.e_data);
        end

        // Mid-operation async reset: busy[4] set, a write in the output register,
        // and an ALU grant pending when rst_n drops between clock edges.
        // rr_ptr is 0 here; MEM is the only requester.
        flush = 1'b0; issue_valid = 1'b1; issue_sel = 4'd4;
        chk_sel_ra = 4'd4; chk_sel_rb = 4'd0; chk_sel_rc = 4'd0;
        src_valid = 3'b010; src_sel[1] = 4'd12; src_data[1] = 32'hCC;
        @(posedge clk); #1;
        chk("pre_rst_we",  0, 32'(rf_write_en), 32'h1);
        issue_valid = 1'b0;
        src_valid = 3'b001; src_sel[0] = 4'd4; src_data[0] = 32'h44;
        #1;
        chk("pre_rst_ir",   0, 32'(issue_ready), 32'h0);
        chk("pre_rst_busy", 0, 32'(busy_ra),     32'h1);
        chk("pre_rst_rdy",  0, 32'(src_ready),   32'(3'b001));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we",   0, 32'(rf_write_en),  32'h0);
        chk("async_rst_sel",  0, 32'(rf_write_sel), 32'h0);
        chk("async_rst_data", 0, rf_write_data,     32'h0);
        chk("async_rst_busy", 0, 32'(busy_ra),      32'h0);
        chk("async_rst_ir",   0, 32'(issue_ready),  32'h1);

        // rr_ptr was 2 before reset; after reset ALU must win a full request set.
        @(negedge clk);
        rst_n = 1'b1;
        src_valid = 3'b111;
        src_sel[0] = 4'd13; src_data[0] = 32'hDD;
        src_sel[1] = 4'd14; src_data[1] = 32'hEE;
        src_sel[2] = 4'd15; src_data[2] = 32'hFF;
        #1;
        chk("post_rst_rdy", 0, 32'(src_ready), 32'(3'b001));
        @(posedge clk); #1;
        chk("post_rst_we",   0, 32'(rf_write_en),  32'h1);
        chk("post_rst_sel",  0, 32'(rf_write_sel), 32'd13);
        chk("post_rst_data", 0, rf_write_data,     32'hDD);
        src_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
